// File: rtl/ram_bist_ctrl_pkg.sv
// Shared definitions for the March C- RAM self-test controller: FSM state
// encodings, march element indices and the per-element operation table.
package ram_bist_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WR   = 3'd1,
    ST_RD   = 3'd2,
    ST_CHK  = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  localparam logic [2:0] ELEM_E0 = 3'd0;
  localparam logic [2:0] ELEM_E1 = 3'd1;
  localparam logic [2:0] ELEM_E2 = 3'd2;
  localparam logic [2:0] ELEM_E3 = 3'd3;
  localparam logic [2:0] ELEM_E4 = 3'd4;
  localparam logic [2:0] ELEM_E5 = 3'd5;

  // One march element: address direction, bit value expected on the read,
  // bit value written afterwards and whether the element writes at all.
  typedef struct packed {
    logic down;
    logic rd_val;
    logic wr_val;
    logic has_write;
  } elem_cfg_t;

  // March C-: E0 up w0 | E1 up r0,w1 | E2 up r1,w0 | E3 down r0,w1 |
  //           E4 down r1,w0 | E5 up r0
  function automatic elem_cfg_t elem_cfg(input logic [2:0] elem);
    elem_cfg_t cfg;
    case (elem)
      ELEM_E0: cfg = '{down: 1'b0, rd_val: 1'b0, wr_val: 1'b0, has_write: 1'b1};
      ELEM_E1: cfg = '{down: 1'b0, rd_val: 1'b0, wr_val: 1'b1, has_write: 1'b1};
      ELEM_E2: cfg = '{down: 1'b0, rd_val: 1'b1, wr_val: 1'b0, has_write: 1'b1};
      ELEM_E3: cfg = '{down: 1'b1, rd_val: 1'b0, wr_val: 1'b1, has_write: 1'b1};
      ELEM_E4: cfg = '{down: 1'b1, rd_val: 1'b1, wr_val: 1'b0, has_write: 1'b1};
      default: cfg = '{down: 1'b0, rd_val: 1'b0, wr_val: 1'b0, has_write: 1'b0};
    endcase
    return cfg;
  endfunction

  // Direction only; used to pick the start address of the following element.
  function automatic logic elem_is_down(input logic [2:0] elem);
    return (elem == ELEM_E3) || (elem == ELEM_E4);
  endfunction

endpackage

// File: rtl/ram_bist_ctrl.sv
// March C- self-test initiator for a single-port synchronous RAM. Owns the
// RAM port while busy, stops on the first read mismatch and reports the
// failing address, element and data word.
module ram_bist_ctrl
  import ram_bist_ctrl_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [2:0]        fail_elem,
  output logic [DATA_W-1:0] fail_data,
  output logic [DATA_W-1:0] ram_din,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_w,
  input  logic [DATA_W-1:0] ram_dout
);

  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [2:0]        elem_q;

  elem_cfg_t         cfg;
  logic [DATA_W-1:0] exp_word;
  logic [DATA_W-1:0] wr_word;
  logic              match;
  logic              addr_last;
  logic [2:0]        elem_next;
  logic [ADDR_W-1:0] next_start;

  assign cfg        = elem_cfg(elem_q);
  assign exp_word   = {DATA_W{cfg.rd_val}};
  assign wr_word    = {DATA_W{cfg.wr_val}};
  assign match      = (ram_dout == exp_word);
  assign addr_last  = cfg.down ? (addr_q == '0) : (addr_q == ADDR_MAX);
  assign elem_next  = elem_q + 3'd1;
  assign next_start = elem_is_down(elem_next) ? ADDR_MAX : '0;

  // State register plus address/element counters and the latched result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      elem_q    <= ELEM_E0;
      pass      <= 1'b0;
      fail_addr <= '0;
      fail_elem <= '0;
      fail_data <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            addr_q    <= '0;
            elem_q    <= ELEM_E0;
            pass      <= 1'b0;
            fail_addr <= '0;
            fail_elem <= '0;
            fail_data <= '0;
          end
        end
        ST_WR: begin
          if (addr_last) begin
            elem_q <= elem_next;
            addr_q <= next_start;
          end else begin
            addr_q <= addr_q + ADDR_W'(1);
          end
        end
        ST_CHK: begin
          if (!match) begin
            fail_addr <= addr_q;
            fail_elem <= elem_q;
            fail_data <= ram_dout;
          end else if (addr_last) begin
            if (elem_q == ELEM_E5) begin
              pass <= 1'b1;
            end else begin
              elem_q <= elem_next;
              addr_q <= next_start;
            end
          end else if (cfg.down) begin
            addr_q <= addr_q - ADDR_W'(1);
          end else begin
            addr_q <= addr_q + ADDR_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Next-state decode; start is only honoured from IDLE or DONE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE: if (start) state_d = ST_WR;
      ST_WR:            if (addr_last) state_d = ST_RD;
      ST_RD:            state_d = ST_CHK;
      ST_CHK: begin
        if (!match || (addr_last && (elem_q == ELEM_E5))) state_d = ST_DONE;
        else                                             state_d = ST_RD;
      end
      default:          state_d = ST_IDLE;
    endcase
  end

  // RAM port and status outputs. Address and write data come from registers
  // only; the compare result gates just the write enable in CHK so a failing
  // word is left untouched.
  always_comb begin
    ram_w    = 1'b0;
    ram_din  = '0;
    ram_addr = '0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state_q)
      ST_WR: begin
        busy     = 1'b1;
        ram_w    = 1'b1;
        ram_addr = addr_q;
        ram_din  = wr_word;
      end
      ST_RD: begin
        busy     = 1'b1;
        ram_addr = addr_q;
      end
      ST_CHK: begin
        busy     = 1'b1;
        ram_addr = addr_q;
        if (match && cfg.has_write) begin
          ram_w   = 1'b1;
          ram_din = wr_word;
        end
      end
      ST_DONE: done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ram_bist_ctrl.sv
// Bench for ram_bist_ctrl: 32x4 synchronous RAM model with per-bit stuck-at
// fault injection, a reference March C- model feeding an expected queue, and
// a single check task.
module tb_ram_bist_ctrl;

  localparam int EXP_W = 22;  // {cycles[8:0], pass, addr[4:0], elem[2:0], data[3:0]}

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       busy;
  logic       done;
  logic       pass;
  logic [4:0] fail_addr;
  logic [2:0] fail_elem;
  logic [3:0] fail_data;
  logic [3:0] ram_din;
  logic [4:0] ram_addr;
  logic       ram_w;
  logic [3:0] ram_dout;

  logic       f_en;
  logic [4:0] f_addr;
  logic [3:0] f_sa1;
  logic [3:0] f_sa0;
  logic       scramble;
  logic [3:0] mem [32];

  logic [EXP_W-1:0] exp_q[$];
  int checks_n;
  int errors_n;

  ram_bist_ctrl #(.DATA_W(4), .ADDR_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .pass(pass), .fail_addr(fail_addr), .fail_elem(fail_elem),
    .fail_data(fail_data), .ram_din(ram_din), .ram_addr(ram_addr),
    .ram_w(ram_w), .ram_dout(ram_dout)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] faulty(input logic [3:0] word, input logic [4:0] a);
    if (f_en && (a == f_addr)) return (word | f_sa1) & ~f_sa0;
    return word;
  endfunction

  // RAM model: synchronous read, stuck-at bits applied on the read path.
  always @(posedge clk) begin
    if (scramble) begin
      for (int i = 0; i < 32; i++) mem[i] <= 4'($urandom_range(0, 15));
    end else if (ram_w) begin
      mem[ram_addr] <= ram_din;
    end else begin
      ram_dout <= faulty(mem[ram_addr], ram_addr);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_n++;
    if (obs !== exp) begin
      errors_n++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference March C- run over an ideal memory with the current fault set.
  function automatic logic [EXP_W-1:0] model_run();
    logic [3:0] m [32];
    int         cyc;
    logic       dn, rv, wv, hw;
    logic [3:0] rd;
    logic [4:0] a;
    logic [2:0] el;
    cyc = 32;
    for (int i = 0; i < 32; i++) m[i] = 4'h0;
    for (int e = 1; e <= 5; e++) begin
      dn = (e == 3) || (e == 4);
      rv = (e == 2) || (e == 4);
      wv = (e == 1) || (e == 3);
      hw = (e != 5);
      el = 3'(e);
      for (int i = 0; i < 32; i++) begin
        a = dn ? 5'(31 - i) : 5'(i);
        cyc += 2;
        rd = faulty(m[a], a);
        if (rd != {4{rv}}) return {9'(cyc), 1'b0, a, el, rd};
        if (hw) m[a] = {4{wv}};
      end
    end
    return {9'(cyc), 1'b1, 5'd0, 3'd0, 4'd0};
  endfunction

  task automatic pulse_start(input logic push_exp);
    if (push_exp) exp_q.push_back(model_run());
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  // Wait for done, counting busy cycles; optionally pulse start at cycle poke.
  task automatic wait_done(input int poke, output int cyc, output logic ok);
    cyc = 0;
    ok  = 1'b0;
    for (int k = 0; k < 2000; k++) begin
      if (done) begin
        ok = 1'b1;
        break;
      end
      if (busy) cyc++;
      start = (k == poke);
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic score_run(input string tag, input int poke);
    int               cyc;
    logic             ok;
    logic [EXP_W-1:0] e;
    wait_done(poke, cyc, ok);
    check({tag, "_timeout"}, 32'(ok), 32'd1);
    e = exp_q.pop_front();
    check({tag, "_cycles"},    32'(cyc),       32'(e[21:13]));
    check({tag, "_pass"},      32'(pass),      32'(e[12]));
    check({tag, "_fail_addr"}, 32'(fail_addr), 32'(e[11:7]));
    check({tag, "_fail_elem"}, 32'(fail_elem), 32'(e[6:4]));
    check({tag, "_fail_data"}, 32'(fail_data), 32'(e[3:0]));
    check({tag, "_busy_end"},  32'(busy),      32'd0);
    check({tag, "_ram_w_end"}, 32'(ram_w),     32'd0);
  endtask

  initial begin
    logic [3:0] or_all;
    checks_n = 0;
    errors_n = 0;
    start    = 1'b0;
    f_en     = 1'b0;
    f_addr   = '0;
    f_sa1    = '0;
    f_sa0    = '0;
    scramble = 1'b1;
    rst_n    = 1'b0;

    // 1. reset
    repeat (3) @(negedge clk);
    scramble = 1'b0;
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_pass", 32'(pass), 0);
    check("rst_ram_w", 32'(ram_w), 0);
    check("rst_ram_addr", 32'(ram_addr), 0);
    check("rst_fail_addr", 32'(fail_addr), 0);
    check("rst_fail_elem", 32'(fail_elem), 0);
    check("rst_fail_data", 32'(fail_data), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // 2. fault-free run
    pulse_start(1'b1);
    check("t2_busy_after_start", 32'(busy), 1);
    score_run("t2", -1);
    check("t2_model_pass", 32'(exp_q.size()), 0);
    or_all = '0;
    for (int i = 0; i < 32; i++) or_all |= mem[i];
    check("t2_mem_zero", 32'(or_all), 0);

    // 3. bit0 stuck-at-1 at 0x03
    f_en = 1'b1; f_addr = 5'h03; f_sa1 = 4'h1; f_sa0 = 4'h0;
    pulse_start(1'b1);
    score_run("t3", -1);
    check("t3_fail_addr_abs", 32'(fail_addr), 32'h03);
    check("t3_fail_elem_abs", 32'(fail_elem), 1);
    check("t3_fail_data_abs", 32'(fail_data), 32'h1);

    // 6. fault removed: results cleared on start, then full pass
    f_en = 1'b0;
    pulse_start(1'b1);
    check("t6_done_clr", 32'(done), 0);
    check("t6_pass_clr", 32'(pass), 0);
    check("t6_fail_addr_clr", 32'(fail_addr), 0);
    check("t6_fail_elem_clr", 32'(fail_elem), 0);
    check("t6_fail_data_clr", 32'(fail_data), 0);
    score_run("t6", -1);
    check("t6_pass_abs", 32'(pass), 1);

    // 4. bit3 stuck-at-0 at 0x1E
    f_en = 1'b1; f_addr = 5'h1E; f_sa1 = 4'h0; f_sa0 = 4'h8;
    pulse_start(1'b1);
    score_run("t4", -1);
    check("t4_fail_addr_abs", 32'(fail_addr), 32'h1E);
    check("t4_fail_elem_abs", 32'(fail_elem), 2);
    check("t4_fail_data_abs", 32'(fail_data), 32'h7);

    // 5. start while busy ignored; async reset mid-test; then full pass
    f_en = 1'b0;
    pulse_start(1'b1);
    score_run("t5a", 50);
    check("t5a_cycles_abs", 32'(busy) + 32'(pass), 1);
    pulse_start(1'b0);
    repeat (100) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("t5_rst_busy", 32'(busy), 0);
    check("t5_rst_ram_w", 32'(ram_w), 0);
    check("t5_rst_done", 32'(done), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    pulse_start(1'b1);
    score_run("t5b", -1);
    check("t5b_pass_abs", 32'(pass), 1);

    $display("CHECKS %0d ERRORS %0d", checks_n, errors_n);
    $finish;
  end

endmodule
